toy_bus_age_arb_node: RTL
=========================

Name: toy_bus_age_arb_node

Overview:
- Parametrised N-input, 1-output arbitration node for the toy bus fabric.
- Successor to the fixed 2-input age-matrix arbiter node. Adds:
  - configurable input count and payload width;
  - a real packet lock, so multi-beat messages are never interleaved;
  - an optional output register stage.
- Sits at every network merge point, between decoders and the downstream link.

Parameters:
- NUM_IN, 4, number of input channels (2..16).
- PLD_W, 275, flattened payload width (opcode + data + sideband + src_id + tgt_id = 1+256+10+4+4).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  NUM_IN  per-input valid.
- in_rdy  output  NUM_IN  per-input ready.
- in_last  input  NUM_IN  per-input last-beat-of-packet flag.
- in_pld  input  NUM_IN*PLD_W  payloads; input i occupies bits [i*PLD_W +: PLD_W].
- out_vld  output  1  output valid.
- out_rdy  input  1  output ready.
- out_last  output  1  last flag of the selected beat.
- out_pld  output  PLD_W  selected payload.
- out_grant  output  NUM_IN  one-hot index of the input driving the output (debug/perf).

Interface decision:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Age matrix:
  - NUM_IN x NUM_IN flops, age[i][j] for i != j; the diagonal is unused.
  - age[i][j]=1 means input j is older than input i, so j beats i.
  - Reset value: age[i][j]=1 when j<i, 0 otherwise. Input 0 is therefore oldest after reset.
  - Invariant: for i != j, exactly one of age[i][j] and age[j][i] is 1.
- Select, combinational, when unlocked:
  - sel[i] = in_vld[i] & ~|(age[i][j] & in_vld[j]) over all j != i.
  - sel is one-hot when any input is valid, and all-zero otherwise.
- Age update:
  - Fires on the accepted beat with last set, i.e. fire_i = in_vld[i] & in_rdy[i] & in_last[i].
  - Input i becomes youngest: age[i][j] <= 1 and age[j][i] <= 0 for all j != i.
  - Non-last beats do not update the age matrix.
- Lock:
  - lock_q and lock_idx_q reset to 0.
  - Set: an accepted beat with in_last=0 sets lock_q=1 and lock_idx_q=i.
  - While locked, the grant is forced to one-hot(lock_idx_q), whether or not that input is valid. A locked input with vld=0 produces a bubble; other inputs stay blocked.
  - Clear: an accepted beat with in_last=1 from the locked input clears lock_q.
  - Single-beat packets (last=1 on the first beat) never set the lock.
- Handshake (without the macro):
  - out_vld = |(grant & in_vld).
  - out_pld and out_last are an AND-OR mux by grant.
  - in_rdy[i] = grant[i] & out_rdy.
  - Zero latency. At most one input is accepted per cycle.
  - in_rdy is not dependent on in_vld of the same input beyond the selection itself.
- out_grant equals the grant vector. Reset: out_vld=0, out_last=0, out_grant=0, out_pld=0.
- Simultaneous requests: the oldest wins, and the winner becomes youngest after its last beat. With all inputs continuously valid this gives round-robin order.
- Reset mid-packet: lock and age are cleared asynchronously to their reset values. Upstream is responsible for packet restart.

Optional Feature:
- Macro: TOY_BUS_ARB_OUT_REG_EN.
- When defined:
  - A 1-entry pipeline register is inserted on out_vld/out_pld/out_last/out_grant, adding 1-cycle latency.
  - The register loads when ~out_vld_q | out_rdy, and in_rdy[i] = grant[i] & (~out_vld_q | out_rdy).
  - Full throughput is kept under continuous out_rdy=1.
  - Lock and age updates occur on the input-side accept.
  - The registered outputs reset to 0.
- When undefined: the combinational path described above is used.

Test Plan:
- Reset release, no inputs valid -> out_vld=0, in_rdy=0, out_grant=0.
- All 4 inputs valid with single-beat packets, out_rdy=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
- in2 sends a 3-beat packet (last on beat 3) while in0 and in1 are valid -> out_grant=4'b0100 for 3 consecutive accepts. in2 drops vld on beat 2 for 2 cycles -> out_vld=0 and in0/in1 stay blocked. Afterwards in2 is youngest.
- out_rdy=0 for 5 cycles with in1 valid -> out_vld=1, out_pld stable equal to in1 payload, no age update. Raising out_rdy -> a single accept.
- Assert rst_n=0 mid-packet while locked on in3 -> after release lock_q=0, and in0 wins the next contention against in3.
- With TOY_BUS_ARB_OUT_REG_EN: continuous traffic on in0 with out_rdy=1 -> out_vld lags by 1 cycle with one beat per cycle. out_rdy low for 1 cycle -> no beat lost or duplicated.

Source files
------------

// File: rtl/toy_bus_age_arb_node.sv
// N-input age-matrix arbiter with packet lock for the toy bus fabric.
// Define TOY_BUS_ARB_OUT_REG_EN to add a 1-entry output register stage.
module toy_bus_age_arb_node #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned PLD_W  = 275
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_vld,
    output logic [NUM_IN-1:0]       in_rdy,
    input  logic [NUM_IN-1:0]       in_last,
    input  logic [NUM_IN*PLD_W-1:0] in_pld,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    out_last,
    output logic [PLD_W-1:0]        out_pld,
    output logic [NUM_IN-1:0]       out_grant
);

    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // Row i holds a 1 in column j when input j is older than input i.
    function automatic logic [NUM_IN-1:0][NUM_IN-1:0] age_init();
        logic [NUM_IN-1:0][NUM_IN-1:0] a;
        a = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            for (int unsigned j = 0; j < NUM_IN; j++) begin
                a[i][j] = (j < i);
            end
        end
        return a;
    endfunction

    localparam logic [NUM_IN-1:0][NUM_IN-1:0] AGE_RST = age_init();

    logic [NUM_IN-1:0][NUM_IN-1:0] age_q, age_d;
    logic                          lock_q, lock_d;
    logic [IDX_W-1:0]              lock_idx_q, lock_idx_d;

    logic [NUM_IN-1:0] sel;
    logic [NUM_IN-1:0] lock_oh;
    logic [NUM_IN-1:0] grant;
    logic [NUM_IN-1:0] acc;
    logic              take;
    logic              mux_vld;
    logic              mux_last;
    logic [PLD_W-1:0]  mux_pld;

`ifdef TOY_BUS_ARB_OUT_REG_EN
    logic              out_vld_q;
    logic              out_last_q;
    logic [PLD_W-1:0]  out_pld_q;
    logic [NUM_IN-1:0] out_grant_q;

    assign take = ~out_vld_q | out_rdy;
`else
    assign take = out_rdy;
`endif

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin : g_sel
            logic older;
            older = 1'b0;
            for (int unsigned j = 0; j < NUM_IN; j++) begin
                if (j != i && age_q[i][j] && in_vld[j]) begin
                    older = 1'b1;
                end
            end
            sel[i] = in_vld[i] & ~older;
        end
    end

    always_comb begin
        lock_oh = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            lock_oh[i] = (lock_idx_q == IDX_W'(i));
        end
    end

    // A locked grant holds even when the owner is idle, so other inputs see a bubble.
    assign grant  = lock_q ? lock_oh : sel;
    assign in_rdy = grant & {NUM_IN{take}};
    assign acc    = in_rdy & in_vld;

    always_comb begin
        mux_vld  = |(grant & in_vld);
        mux_last = |(grant & in_last);
        mux_pld  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            mux_pld = mux_pld | (in_pld[i*PLD_W +: PLD_W] & {PLD_W{grant[i]}});
        end
    end

    always_comb begin
        age_d = age_q;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (acc[i] && in_last[i]) begin
                for (int unsigned j = 0; j < NUM_IN; j++) begin
                    if (j != i) begin
                        age_d[i][j] = 1'b1;
                        age_d[j][i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (acc[i]) begin
                if (!in_last[i]) begin
                    lock_d     = 1'b1;
                    lock_idx_d = IDX_W'(i);
                end else if (lock_q && lock_idx_q == IDX_W'(i)) begin
                    lock_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q      <= AGE_RST;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            age_q      <= age_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef TOY_BUS_ARB_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_pld_q   <= '0;
            out_grant_q <= '0;
        end else if (take) begin
            out_vld_q   <= mux_vld;
            out_last_q  <= mux_last;
            out_pld_q   <= mux_pld;
            out_grant_q <= grant;
        end
    end

    assign out_vld   = out_vld_q;
    assign out_last  = out_last_q;
    assign out_pld   = out_pld_q;
    assign out_grant = out_grant_q;
`else
    assign out_vld   = mux_vld;
    assign out_last  = mux_last;
    assign out_pld   = mux_pld;
    assign out_grant = grant;
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_acc_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(acc));

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_age_chk
        for (genvar gj = gi + 1; gj < NUM_IN; gj++) begin : g_pair
            a_age_antisym: assert property (@(posedge clk) disable iff (!rst_n)
                age_q[gi][gj] ^ age_q[gj][gi]);
        end
    end

endmodule
